// File: rtl/fdiv_sched_if.sv
// fdiv_sched_if: requester, datapath and result signals of the divider scheduler.
//   a_*/b_*    : two requesters (req, operands x1/x2, tag, combinational gnt)
//   flush      : kill all in-flight operations
//   dp_*       : issue register to the divider pipeline and its quotient/overflow return
//   res_*      : registered result bus with source and tag
//   ovf_sticky : per-requester sticky overflow, cleared by ovf_clr
//   busy       : anything in flight or on the result bus
interface fdiv_sched_if #(parameter int TAGW = 5);
    logic            a_req, b_req, a_gnt, b_gnt, flush;
    logic [31:0]     a_x1, a_x2, b_x1, b_x2;
    logic [TAGW-1:0] a_tag, b_tag;
    logic            dp_valid, dp_ovf;
    logic [31:0]     dp_x1, dp_x2, dp_y;
    logic            res_valid, res_src, res_ovf, busy;
    logic [TAGW-1:0] res_tag;
    logic [31:0]     res_y;
    logic [1:0]      ovf_sticky, ovf_clr;

    modport slave (
        input  a_req, a_x1, a_x2, a_tag, b_req, b_x1, b_x2, b_tag, flush, dp_y, dp_ovf, ovf_clr,
        output a_gnt, b_gnt, dp_valid, dp_x1, dp_x2, res_valid, res_src, res_tag, res_y, res_ovf,
               ovf_sticky, busy
    );
    modport master (
        output a_req, a_x1, a_x2, a_tag, b_req, b_x1, b_x2, b_tag, flush, dp_y, dp_ovf, ovf_clr,
        input  a_gnt, b_gnt, dp_valid, dp_x1, dp_x2, res_valid, res_src, res_tag, res_y, res_ovf,
               ovf_sticky, busy
    );
endinterface

// File: rtl/fdiv_sched.sv
// fdiv_sched: round-robin issue scheduler and fixed-latency result tracker for the divider.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : fdiv_sched_if.slave (requesters, divider pipeline, result bus, sticky overflow)
module fdiv_sched #(
    parameter int LATENCY = 4,
    parameter int TAGW    = 5
) (
    input logic         clk,
    input logic         rstn,
    fdiv_sched_if.slave bus
);
    logic                last, win_b, gnt, dp_src;
    logic [TAGW-1:0]     dp_tag;
    logic [LATENCY-1:0]  tv, tsrc;
    logic [TAGW-1:0]     ttag [LATENCY];

    // last = 1 means B won most recently, so A takes the next contended cycle
    assign win_b     = bus.b_req & (~bus.a_req | ~last);
    assign bus.a_gnt = ~bus.flush & bus.a_req & ~win_b;
    assign bus.b_gnt = ~bus.flush & win_b;
    assign gnt       = bus.a_gnt | bus.b_gnt;
    assign bus.busy  = bus.dp_valid | (|tv) | bus.res_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last           <= 1'b1;
            bus.dp_valid   <= 1'b0;
            bus.dp_x1      <= '0;
            bus.dp_x2      <= '0;
            dp_src         <= 1'b0;
            dp_tag         <= '0;
            tv             <= '0;
            tsrc           <= '0;
            for (int i = 0; i < LATENCY; i++) ttag[i] <= '0;
            bus.res_valid  <= 1'b0;
            bus.res_src    <= 1'b0;
            bus.res_tag    <= '0;
            bus.res_y      <= '0;
            bus.res_ovf    <= 1'b0;
            bus.ovf_sticky <= '0;
        end else begin
            if (gnt) begin
                last      <= win_b;
                bus.dp_x1 <= win_b ? bus.b_x1 : bus.a_x1;
                bus.dp_x2 <= win_b ? bus.b_x2 : bus.a_x2;
                dp_src    <= win_b;
                dp_tag    <= win_b ? bus.b_tag : bus.a_tag;
            end
            bus.dp_valid <= gnt;
            // the tracker mirrors the pipeline and never stalls; flush only drops the valid bits
            tv      <= bus.flush ? '0 : (tv << 1) | LATENCY'(bus.dp_valid);
            tsrc    <= (tsrc << 1) | LATENCY'(dp_src);
            ttag[0] <= dp_tag;
            for (int i = 1; i < LATENCY; i++) ttag[i] <= ttag[i-1];
            bus.res_valid <= tv[LATENCY-1] & ~bus.flush;
            if (tv[LATENCY-1]) begin
                bus.res_src <= tsrc[LATENCY-1];
                bus.res_tag <= ttag[LATENCY-1];
                bus.res_y   <= bus.dp_y;
                bus.res_ovf <= bus.dp_ovf;
            end
            // set is ORed after the clear so a coincident set wins
            bus.ovf_sticky <= (bus.ovf_sticky & ~bus.ovf_clr)
                            | ({bus.res_src, ~bus.res_src} & {2{bus.res_valid & bus.res_ovf}});
        end
    end
endmodule

// File: tb/tb_fdiv_sched.sv
// tb_fdiv_sched: table, directed and random checks of fdiv_sched against a scoreboard model.
module tb_fdiv_sched;
    localparam int LAT = 4;
    localparam int TW  = 5;

    logic clk = 0, rstn = 0;
    int   n_tests = 0, n_fail = 0, cyc = 0;

    fdiv_sched_if #(.TAGW(TW)) ifc ();
    fdiv_sched #(.LATENCY(LAT), .TAGW(TW)) dut (.clk(clk), .rstn(rstn), .bus(ifc.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // simplified single-precision divide: truncated mantissa ratio, overflow when exponent > 254
    function automatic logic [32:0] fq(input logic [31:0] x1, input logic [31:0] x2);
        int          e;
        logic [63:0] ma, mb, q;
        ma = {40'd0, 1'b1, x1[22:0]};
        mb = {40'd0, 1'b1, x2[22:0]};
        e  = int'(x1[30:23]) - int'(x2[30:23]) + 127;
        q  = (ma << 23) / mb;
        if (!q[23]) begin
            q = (ma << 24) / mb;
            e = e - 1;
        end
        if (e > 254) return {1'b1, x1[31] ^ x2[31], 8'hFF, 23'd0};
        return {1'b0, x1[31] ^ x2[31], e[7:0], q[22:0]};
    endfunction

    // divider pipeline: operands taken every edge, quotient LAT cycles later
    logic [31:0] px1 [LAT];
    logic [31:0] px2 [LAT];
    logic [32:0] pr;
    always @(posedge clk) begin
        px1[0] <= ifc.dp_x1;
        px2[0] <= ifc.dp_x2;
        for (int i = 1; i < LAT; i++) begin
            px1[i] <= px1[i-1];
            px2[i] <= px2[i-1];
        end
    end
    assign pr         = fq(px1[LAT-1], px2[LAT-1]);
    assign ifc.dp_y   = pr[31:0];
    assign ifc.dp_ovf = pr[32];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // scoreboard: each grant predicts one result LAT+2 cycles later
    typedef struct {
        int              due;
        logic            src;
        logic [TW-1:0]   tag;
        logic [32:0]     q;
    } exp_t;
    exp_t       sb[$];
    exp_t       e;
    logic       m_last, wb, ga, gb, ev;
    logic [1:0] m_sticky, st;

    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
            m_last   = 1'b1;
            m_sticky = 2'b00;
            chk("rst_dp_valid", ifc.dp_valid, 0);
            chk("rst_res_valid", ifc.res_valid, 0);
            chk("rst_busy", ifc.busy, 0);
            chk("rst_sticky", ifc.ovf_sticky, 0);
        end else begin
            wb = ifc.b_req & (!ifc.a_req | !m_last);
            ga = !ifc.flush & ifc.a_req & !wb;
            gb = !ifc.flush & wb;
            chk("a_gnt", ifc.a_gnt, ga);
            chk("b_gnt", ifc.b_gnt, gb);
            chk("gnt_mutex", ifc.a_gnt & ifc.b_gnt, 0);
            chk("busy", ifc.busy, sb.size() != 0);
            ev = sb.size() != 0 && sb[0].due == cyc;
            chk("res_valid", ifc.res_valid, ev);
            st = 2'b00;
            if (ev) begin
                e = sb.pop_front();
                chk("res_src", ifc.res_src, e.src);
                chk("res_tag", ifc.res_tag, e.tag);
                chk("res_y", ifc.res_y, e.q[31:0]);
                chk("res_ovf", ifc.res_ovf, e.q[32]);
                if (e.q[32]) st[e.src] = 1'b1;
            end
            chk("ovf_sticky", ifc.ovf_sticky, m_sticky);
            if (ifc.flush) sb.delete();
            m_sticky = (m_sticky & ~ifc.ovf_clr) | st;
            if (ga | gb) begin
                m_last = gb;
                sb.push_back('{cyc + LAT + 2, gb, gb ? ifc.b_tag : ifc.a_tag,
                               gb ? fq(ifc.b_x1, ifc.b_x2) : fq(ifc.a_x1, ifc.a_x2)});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifc.a_req = 0; ifc.b_req = 0; ifc.flush = 0; ifc.ovf_clr = 0;
    endtask

    task automatic do_reset();
        step(); idle(); rstn = 0;
        step(); rstn = 1;
    endtask

    typedef struct {
        logic a, b, f, ga, gb;
    } vec_t;
    vec_t tbl [13];

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1, 1, 0, 1, 0};
        tbl[1]  = '{1, 1, 0, 0, 1};
        tbl[2]  = '{1, 1, 0, 1, 0};
        tbl[3]  = '{1, 1, 0, 0, 1};
        tbl[4]  = '{1, 1, 0, 1, 0};
        tbl[5]  = '{1, 1, 0, 0, 1};
        tbl[6]  = '{0, 1, 0, 0, 1};
        tbl[7]  = '{1, 1, 0, 1, 0};
        tbl[8]  = '{1, 0, 0, 1, 0};
        tbl[9]  = '{1, 1, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 0};
        tbl[11] = '{1, 1, 1, 0, 0};
        tbl[12] = '{0, 0, 0, 0, 0};

        idle();
        ifc.a_x1 = 0; ifc.a_x2 = 0; ifc.a_tag = 0;
        ifc.b_x1 = 0; ifc.b_x2 = 0; ifc.b_tag = 0;
        repeat (2) step();
        rstn = 1;

        // single op 6.0 / 2.0
        step();
        ifc.a_req = 1; ifc.a_x1 = 32'h40C00000; ifc.a_x2 = 32'h40000000; ifc.a_tag = 3;
        #1 chk("single_gnt", ifc.a_gnt, 1);
        for (int c = 1; c <= 6; c++) begin
            step(); idle();
            #1;
            if (c == 1) chk("single_dp_valid", ifc.dp_valid, 1);
            chk("single_res_valid", ifc.res_valid, c == 6);
        end
        chk("single_res_y", ifc.res_y, 32'h40400000);
        chk("single_res_src", ifc.res_src, 0);
        chk("single_res_tag", ifc.res_tag, 3);

        // arbitration table from reset
        do_reset();
        ifc.a_x1 = 32'h40C00000; ifc.a_x2 = 32'h40000000;
        ifc.b_x1 = 32'h41100000; ifc.b_x2 = 32'h40400000;
        for (int i = 0; i < 13; i++) begin
            step();
            ifc.a_req = tbl[i].a; ifc.b_req = tbl[i].b; ifc.flush = tbl[i].f;
            ifc.a_tag = TW'(i); ifc.b_tag = TW'(i + 16);
            #1;
            chk("tbl_a_gnt", ifc.a_gnt, tbl[i].ga);
            chk("tbl_b_gnt", ifc.b_gnt, tbl[i].gb);
        end
        idle();
        repeat (10) step();

        // flush mid-flight, then a fresh op right after
        for (int c = 0; c <= 11; c++) begin
            step(); idle();
            if (c <= 2) begin ifc.a_req = 1; ifc.a_tag = TW'(c); end
            if (c == 4) ifc.flush = 1;
            if (c == 5) begin ifc.a_req = 1; ifc.a_tag = 9; end
            #1;
            if (c == 5) chk("flush_busy", ifc.busy, 0);
            if (c >= 5) chk("flush_res_valid", ifc.res_valid, c == 11);
        end
        chk("flush_res_tag", ifc.res_tag, 9);

        // sticky overflow on B, coincident set/clear, then lone clear
        do_reset();
        ifc.b_x1 = 32'h7F000000; ifc.b_x2 = 32'h00800000;
        for (int c = 0; c <= 10; c++) begin
            step(); idle();
            if (c <= 1) begin ifc.b_req = 1; ifc.b_tag = TW'(c + 1); end
            if (c == 7 || c == 9) ifc.ovf_clr = 2'b10;
            #1;
            if (c == 6) chk("ovf_res_ovf", ifc.res_ovf, 1);
            if (c == 7) chk("ovf_sticky_set", ifc.ovf_sticky, 2'b10);
            if (c == 8) chk("ovf_set_wins", ifc.ovf_sticky, 2'b10);
            if (c == 10) chk("ovf_cleared", ifc.ovf_sticky, 2'b00);
        end

        // reset with four ops in flight
        ifc.a_x1 = 32'h40C00000; ifc.a_x2 = 32'h40000000;
        ifc.b_x1 = 32'h7F000000; ifc.b_x2 = 32'h00800000;
        for (int c = 0; c <= 3; c++) begin
            step(); ifc.a_req = 1; ifc.b_req = 1;
        end
        step(); idle(); rstn = 0;
        #1;
        chk("mid_rst_dp_valid", ifc.dp_valid, 0);
        chk("mid_rst_res_valid", ifc.res_valid, 0);
        chk("mid_rst_busy", ifc.busy, 0);
        chk("mid_rst_dp_x1", ifc.dp_x1, 0);
        chk("mid_rst_dp_x2", ifc.dp_x2, 0);
        chk("mid_rst_res", {ifc.res_y, ifc.res_tag, ifc.res_src, ifc.res_ovf, ifc.ovf_sticky}, 0);
        step(); rstn = 1;
        for (int c = 0; c < 10; c++) begin
            step();
            #1 chk("mid_rst_no_stale", ifc.res_valid, 0);
        end
        step(); ifc.a_req = 1; ifc.b_req = 1;
        #1;
        chk("mid_rst_a_first", ifc.a_gnt, 1);
        chk("mid_rst_b_wait", ifc.b_gnt, 0);

        // random traffic against the scoreboard
        for (int i = 0; i < 800; i++) begin
            step();
            ifc.a_req   = ($urandom % 3) != 0;
            ifc.b_req   = ($urandom % 3) != 0;
            ifc.flush   = ($urandom % 25) == 0;
            ifc.ovf_clr = (($urandom % 6) == 0) ? 2'($urandom) : 2'b00;
            ifc.a_x1 = $urandom; ifc.a_x2 = $urandom; ifc.a_tag = TW'($urandom);
            ifc.b_x1 = $urandom; ifc.b_x2 = $urandom; ifc.b_tag = TW'($urandom);
        end
        idle();
        repeat (LAT + 6) step();
        chk("drain_busy", ifc.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fdiv_sched.md
# fdiv_sched

Issue scheduler and result tracker for the split floating-point divider pipeline. Two requesters share the pipeline, for example the FPU issue port and a microcode/sqrt helper. The block arbitrates between them round-robin, issues at most one operand pair per cycle, and tracks each in-flight operation's source and destination tag through the fixed pipeline latency. It returns each result with its tag on a single registered result bus, and keeps sticky per-requester overflow flags.

## Interface
- LATENCY, 4: cycles from `dp_valid` high to matching `dp_y`/`dp_ovf` valid; legal range 1..16.
- TAGW, 5: destination-tag width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- a_req  in  1  requester A has an operation this cycle.
- a_x1, a_x2  in  32  A's dividend and divisor (IEEE-754 single).
- a_tag  in  TAGW  A's destination tag.
- a_gnt  out  1  combinational; A's operation is accepted this cycle.
- b_req, b_x1, b_x2, b_tag, b_gnt  same as above, for requester B.
- flush  in  1  kill all in-flight operations.
- dp_valid  out  1  registered; operands are presented to the pipeline.
- dp_x1, dp_x2  out  32  registered operands.
- dp_y  in  32  pipeline quotient.
- dp_ovf  in  1  pipeline exponent overflow.
- res_valid  out  1  registered; a result is on the bus.
- res_src  out  1  0 = A, 1 = B.
- res_tag  out  TAGW  tag of the result.
- res_y  out  32  registered copy of `dp_y`.
- res_ovf  out  1  registered copy of `dp_ovf`.
- ovf_sticky  out  2  bit0 = A, bit1 = B; set by overflowing results.
- ovf_clr  in  2  per-requester clear of `ovf_sticky`.
- busy  out  1  `dp_valid`, any tracker entry, or `res_valid` is high.

## Operation
- Arbitration is combinational from `a_req`, `b_req`, `flush` and the round-robin pointer `last` (1 bit).
  - Only one requester requesting: that requester is granted.
  - Both requesting: the requester that is not `last` is granted.
  - `last` updates to the winner only on a cycle with a grant.
  - `flush` high: no grant that cycle.
  - At most one grant per cycle; `a_gnt & b_gnt` is never 1.
- Issue: on a grant, the next edge loads `dp_x1`/`dp_x2` from the winner and sets `dp_valid` = 1. With no grant, `dp_valid` = 0 and the operands hold their last value.
- Tracker: a LATENCY-deep shift register of {v, src, tag}.
  - Stage 0 is loaded from the issue register each edge (v = `dp_valid`).
  - Entries shift by one stage per cycle; the tracker never stalls.
- Retire: when the last tracker stage has v = 1, the next edge loads `res_valid` = 1 with `res_src`/`res_tag` from that stage and `res_y`/`res_ovf` from `dp_y`/`dp_ovf`. Otherwise `res_valid` = 0.
- No backpressure. Requesters must accept a result in the cycle `res_valid` is high.
- Flush: on an edge with `flush` = 1, the block clears `dp_valid`, every tracker v bit and `res_valid`. A flushed operation never produces `res_valid`. Flush leaves `ovf_sticky` and `last` unchanged.
- Sticky overflow: `ovf_sticky[res_src]` sets on any cycle with `res_valid` & `res_ovf` (non-flushed). `ovf_clr[i]` clears bit i. When set and clear coincide, set wins.
- Throughput: one operation per cycle sustained; results leave in issue order.

## Timing
- Reset (`rstn` low, asynchronous) sets:
  - `dp_valid`, `res_valid`, all tracker v bits, `ovf_sticky` and `busy` to 0;
  - `dp_x1`, `dp_x2`, `res_y`, `res_tag`, `res_src`, `res_ovf` to 0;
  - `last` to 1, so A wins the first contended cycle.
- A grant in cycle t gives:
  - `dp_valid` in cycle t+1;
  - `dp_y` sampled in cycle t+1+LATENCY;
  - `res_valid` in cycle t+2+LATENCY. Total grant-to-result latency is LATENCY+2.
- `flush` in cycle t: no grant in t; from t+1 all valids are 0. A request arriving in t+1 is granted normally; its result appears in t+3+LATENCY.
- Reset asserted mid-operation discards every in-flight operation. The first grant after `rstn` rises follows the normal timing.
- `ovf_sticky` reflects a set or clear from the edge following the event.

## Test plan
- Single op: A requests 6.0/2.0 (`a_x1`=0x40C00000, `a_x2`=0x40000000, tag 3) in cycle 0 -> `a_gnt`=1 in cycle 0; `dp_valid` in cycle 1; `res_valid` with `res_y`=0x40400000, `res_src`=0, `res_tag`=3 in cycle 6 (LATENCY=4).
- Contention: A and B request every cycle for 6 cycles from reset -> grants A,B,A,B,A,B; results return in the same order with matching tags, one per cycle, no bubbles.
- Flush mid-flight: issue 3 ops in cycles 0–2, assert `flush` in cycle 4 -> `res_valid` never rises for them. `busy`=0 from cycle 5. A fresh op in cycle 5 returns in cycle 11.
- Overflow sticky: B issues 0x7F000000/0x00800000 (quotient exponent overflows, `dp_ovf`=1 from the model) -> `res_ovf`=1, `ovf_sticky`=2'b10. Pulse `ovf_clr`=2'b10 in the same cycle as a second overflowing B result -> the bit stays 1. A later lone clear -> 0.
- Reset mid-op: drop `rstn` for one cycle with 4 ops in flight -> all outputs at reset values immediately and no stale `res_valid` afterwards. Next A/B contention grants A first.
- Bench drives the datapath with a fixed LATENCY-cycle reference model and checks that no cycle ever has both `a_gnt` and `b_gnt` high.
